noc_demux2: RTL and testbench



---
 rtl/noc_pkg.sv | 23 ++
 rtl/noc_flit_buf.sv | 41 ++++
 rtl/noc_demux2.sv | 124 ++++++++++++
 tb/tb_noc_demux2.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: route FSM encoding and the flit framing-flag layout.
// The demux top and anything else on the flit path pull these in with a package import.
package noc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } route_state_e;

  typedef struct packed {
    logic head;
    logic tail;
  } flit_flags_t;

  localparam int FLAGS_W = $bits(flit_flags_t);

  // A packet that is still open after its head locks onto the port the head chose.
  function automatic route_state_e lock_state(input logic port);
    return port ? ST_LOCK1 : ST_LOCK0;
  endfunction

endpackage

// File: rtl/noc_flit_buf.sv
// Single-entry valid/ready register slice. It accepts a new word in the same cycle
// the held word drains, so a continuously ready sink sees one word per cycle.
module noc_flit_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         buf_v;
  logic [W-1:0] buf_q;
  logic         load;
  logic         drain;

  assign in_ready  = !buf_v || out_ready;
  assign load      = in_valid && in_ready;
  assign drain     = buf_v && out_ready;
  assign out_valid = buf_v;
  assign out_data  = buf_q;

  // NOTE: the payload register is reset along with the valid bit because every
  // output of the demux, shared out_data included, must read 0 while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_v <= 1'b0;
      buf_q <= '0;
    end else if (load) begin
      buf_v <= 1'b1;
      buf_q <= in_data;
    end else if (drain) begin
      buf_v <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_demux2.sv
// 1-to-2 wormhole flit demultiplexer: a head flit picks the output port, the rest of
// the packet follows it until the tail, and one register slice decouples input from outputs.
module noc_demux2
  import noc_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEST_BIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_head,
  input  logic              in_tail,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_head,
  output logic              out_tail,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic              err
);

  localparam int BUF_W = DATA_W + FLAGS_W + 1;

  route_state_e      state;
  flit_flags_t       in_flags;
  flit_flags_t       out_flags;
  logic              out_port;
  logic              sel;
  logic              acc;
  logic              fwd;
  logic              buf_in_ready;
  logic              buf_v;
  logic              sel_ready;
  logic              drain;
  logic [BUF_W-1:0]  buf_din;
  logic [BUF_W-1:0]  buf_dout;

  assign in_flags = '{head: in_head, tail: in_tail};

  // Gated by rst so the upstream never sees a ready while the slice is being cleared.
  assign in_ready = buf_in_ready && !rst;
  assign acc      = in_valid && in_ready;

  // A body flit with no open packet has nowhere to go and is consumed without loading.
  assign fwd = in_head || (state != ST_IDLE);

  // NOTE: every signal assigned in an always_comb gets a default first, so a missed
  // branch cannot turn into an inferred latch.
  always_comb begin
    sel = 1'b0;
    if (in_head) begin
      sel = in_data[DEST_BIT];
    end else begin
      sel = (state == ST_LOCK1);
    end
  end

  assign buf_din = {in_data, in_flags, sel};

  noc_flit_buf #(
    .W(BUF_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (acc && fwd),
    .in_ready (buf_in_ready),
    .in_data  (buf_din),
    .out_valid(buf_v),
    .out_ready(sel_ready),
    .out_data (buf_dout)
  );

  assign {out_data, out_flags, out_port} = buf_dout;
  assign out_head = out_flags.head;
  assign out_tail = out_flags.tail;

  // Only the ready of the port holding the buffered flit matters.
  assign sel_ready  = out_port ? out1_ready : out0_ready;
  assign drain      = buf_v && sel_ready;
  assign out0_valid = buf_v && !out_port;
  assign out1_valid = buf_v && out_port;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      err   <= 1'b0;
    end else if (acc) begin
      if (in_head) begin
        // A head while a packet is open means the previous tail went missing.
        if (state != ST_IDLE) begin
          err <= 1'b1;
        end
        state <= in_tail ? ST_IDLE : lock_state(sel);
      end else if (state == ST_IDLE) begin
        err <= 1'b1;
      end else if (in_tail) begin
        state <= ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (drain && out_flags.tail) begin
      if (out_port) begin
        pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      end else begin
        pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_noc_demux2.sv
// Directed bench for noc_demux2: a vector table for routing, streaming, backpressure,
// isolation and protocol errors, then hand sequences for async reset and counter wrap.
module tb_noc_demux2;

  localparam int DATA_W   = 16;
  localparam int DEST_BIT = 0;
  localparam int CNT_W    = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_head;
  logic              in_tail;
  logic              out0_valid;
  logic              out0_ready;
  logic              out1_valid;
  logic              out1_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_head;
  logic              out_tail;
  logic [CNT_W-1:0]  pkt_cnt0;
  logic [CNT_W-1:0]  pkt_cnt1;
  logic              err;

  int total = 0;
  int bad   = 0;

  noc_demux2 #(
    .DATA_W  (DATA_W),
    .DEST_BIT(DEST_BIT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_head   (in_head),
    .in_tail   (in_tail),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out_data  (out_data),
    .out_head  (out_head),
    .out_tail  (out_tail),
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              vld;
    logic [DATA_W-1:0] d;
    logic              h;
    logic              t;
    logic              r0;
    logic              r1;
    logic              e_ir;
    logic              e_v0;
    logic              e_v1;
    logic [DATA_W-1:0] e_d;
    logic [CNT_W-1:0]  e_c0;
    logic [CNT_W-1:0]  e_c1;
    logic              e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [DATA_W-1:0] d, input logic h,
                              input logic t, input logic r0, input logic r1, input logic e_ir,
                              input logic e_v0, input logic e_v1, input logic [DATA_W-1:0] e_d,
                              input logic [CNT_W-1:0] e_c0, input logic [CNT_W-1:0] e_c1,
                              input logic e_err);
    vec_t v;
    v.vld = vld; v.d = d; v.h = h; v.t = t; v.r0 = r0; v.r1 = r1;
    v.e_ir = e_ir; v.e_v0 = e_v0; v.e_v1 = e_v1; v.e_d = e_d;
    v.e_c0 = e_c0; v.e_c1 = e_c1; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input logic vld, input logic [DATA_W-1:0] d, input logic h,
                       input logic t, input logic r0, input logic r1);
    in_valid   = vld;
    in_data    = d;
    in_head    = h;
    in_tail    = t;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Columns: vld d h t r0 r1 | in_ready v0 v1 data c0 c1 err (data checked when a port is valid)
    // reset state, then single-flit packet to port 1
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1,  1, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 16'h0001, 1, 1, 1, 1,  1, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1,  1, 0, 1, 16'h0001, 0, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1,  1, 0, 0, 16'h0000, 0, 1, 0));
    // 4-flit stream to port 0; body bit0=1 must not re-steer
    vecs.push_back(mk(1, 16'h0010, 1, 0, 1, 1,  1, 0, 0, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(1, 16'h0011, 0, 0, 1, 1,  1, 1, 0, 16'h0010, 0, 1, 0));
    vecs.push_back(mk(1, 16'h0012, 0, 0, 1, 1,  1, 1, 0, 16'h0011, 0, 1, 0));
    vecs.push_back(mk(1, 16'h0013, 0, 1, 1, 1,  1, 1, 0, 16'h0012, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1,  1, 1, 0, 16'h0013, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1,  1, 0, 0, 16'h0000, 1, 1, 0));
    // backpressure on port 0 for three cycles
    vecs.push_back(mk(1, 16'h0020, 1, 0, 1, 1,  1, 0, 0, 16'h0000, 1, 1, 0));
    vecs.push_back(mk(1, 16'h0022, 0, 0, 0, 1,  0, 1, 0, 16'h0020, 1, 1, 0));
    vecs.push_back(mk(1, 16'h0022, 0, 0, 0, 1,  0, 1, 0, 16'h0020, 1, 1, 0));
    vecs.push_back(mk(1, 16'h0022, 0, 0, 0, 1,  0, 1, 0, 16'h0020, 1, 1, 0));
    vecs.push_back(mk(1, 16'h0022, 0, 0, 1, 1,  1, 1, 0, 16'h0020, 1, 1, 0));
    vecs.push_back(mk(1, 16'h0024, 0, 0, 1, 1,  1, 1, 0, 16'h0022, 1, 1, 0));
    vecs.push_back(mk(1, 16'h0026, 0, 1, 1, 1,  1, 1, 0, 16'h0024, 1, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1,  1, 1, 0, 16'h0026, 1, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1,  1, 0, 0, 16'h0000, 2, 1, 0));
    // port 1 packet while out0_ready is stuck low
    vecs.push_back(mk(1, 16'h0031, 1, 0, 0, 1,  1, 0, 0, 16'h0000, 2, 1, 0));
    vecs.push_back(mk(1, 16'h0032, 0, 0, 0, 1,  1, 0, 1, 16'h0031, 2, 1, 0));
    vecs.push_back(mk(1, 16'h0034, 0, 1, 0, 1,  1, 0, 1, 16'h0032, 2, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 1,  1, 0, 1, 16'h0034, 2, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 1,  1, 0, 0, 16'h0000, 2, 2, 0));
    // body flit in IDLE is dropped and flags err
    vecs.push_back(mk(1, 16'h0040, 0, 0, 1, 1,  1, 0, 0, 16'h0000, 2, 2, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1,  1, 0, 0, 16'h0000, 2, 2, 1));
    // head while LOCK0 re-routes to port 1; truncated packet adds no count
    vecs.push_back(mk(1, 16'h0050, 1, 0, 1, 1,  1, 0, 0, 16'h0000, 2, 2, 1));
    vecs.push_back(mk(1, 16'h0051, 1, 0, 1, 1,  1, 1, 0, 16'h0050, 2, 2, 1));
    vecs.push_back(mk(1, 16'h0052, 0, 1, 1, 1,  1, 0, 1, 16'h0051, 2, 2, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1,  1, 0, 1, 16'h0052, 2, 2, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1,  1, 0, 0, 16'h0000, 2, 3, 1));

    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_valids", 32'({out0_valid, out1_valid}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].d, vecs[i].h, vecs[i].t, vecs[i].r0, vecs[i].r1);
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      check($sformatf("v%0d_out0_valid", i), 32'(out0_valid), 32'(vecs[i].e_v0));
      check($sformatf("v%0d_out1_valid", i), 32'(out1_valid), 32'(vecs[i].e_v1));
      if (vecs[i].e_v0 || vecs[i].e_v1)
        check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_d));
      check($sformatf("v%0d_pkt_cnt0", i), 32'(pkt_cnt0), 32'(vecs[i].e_c0));
      check($sformatf("v%0d_pkt_cnt1", i), 32'(pkt_cnt1), 32'(vecs[i].e_c1));
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e_err));
      @(posedge clk);
      #1;
    end

    // Async reset mid-packet with the buffer full on a stalled port 0.
    drive(1'b1, 16'h0060, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("pre_rst_out0_valid", 32'(out0_valid), 32'd1);
    check("pre_rst_out_data", 32'(out_data), 32'h60);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valids", 32'({out0_valid, out1_valid}), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    check("async_rst_out_data", 32'(out_data), 32'd0);
    check("async_rst_flags", 32'({out_head, out_tail}), 32'd0);
    check("async_rst_cnts", 32'({pkt_cnt0, pkt_cnt1}), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    drive(1'b1, 16'h0061, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("post_rst_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("post_rst_out1_valid", 32'(out1_valid), 32'd1);
    check("post_rst_out0_valid", 32'(out0_valid), 32'd0);
    check("post_rst_out_data", 32'(out_data), 32'h61);
    check("post_rst_out_flags", 32'({out_head, out_tail}), 32'b11);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_cnt1", 32'(pkt_cnt1), 32'd1);
    check("post_rst_cnt0", 32'(pkt_cnt0), 32'd0);
    check("post_rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;

    // 16 back-to-back single-flit packets to port 0: the 4-bit counter wraps to 0.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'h0002 + DATA_W'(i << 4), 1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check($sformatf("wrap%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("wrap_cnt0_15", 32'(pkt_cnt0), 32'd15);
    check("wrap_last_data", 32'(out_data), 32'h00f2);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wrap_cnt0_0", 32'(pkt_cnt0), 32'd0);
    check("wrap_cnt1_hold", 32'(pkt_cnt1), 32'd1);
    check("wrap_out0_idle", 32'(out0_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
